// File: rtl/voxel_mm_pkg.sv
// Shared definitions for the voxel Avalon-MM burst reader.
//  - default address/data widths of the on-chip RAM slave
//  - FSM state encoding
//  - crd_w(): width needed to hold a credit/occupancy count 0..depth
package voxel_mm_pkg;

  localparam int VOX_ADDR_W = 10;
  localparam int VOX_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int crd_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/voxel_rd_fifo.sv
// First-word-fall-through FIFO buffering read data ahead of the stream port.
// Ports:
//  clk, reset_n        clock, async active-low reset
//  push, push_data     write side; accepted when not full or when popping
//  pop, pop_data       read side; pop_data is the head whenever empty=0
//  count, full, empty  occupancy status
module voxel_rd_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop & ~empty;
    // a full FIFO still takes a word when the head leaves in the same cycle
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset; count_q decides what is valid
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/voxel_mm_burst_reader.sv
// Avalon-MM read master that streams word_count consecutive words starting at
// base_addr out of an on-chip RAM onto an Avalon-ST source with sop/eop framing.
// Ports:
//  clk, reset_n                       clock, async active-low reset
//  start, base_addr, word_count       job request (taken only while busy=0)
//  busy, done                         job status; done is a 1-cycle pulse
//  avm_*                              Avalon-MM read master
//  st_data/valid/ready/sop/eop        Avalon-ST source, readyLatency 0
module voxel_mm_burst_reader
  import voxel_mm_pkg::*;
#(
  parameter int ADDR_W     = VOX_ADDR_W,
  parameter int DATA_W     = VOX_DATA_W,
  parameter int CNT_W      = 11,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    word_count,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready,
  output logic                st_sop,
  output logic                st_eop
);

  localparam int CRD_W = crd_w(FIFO_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  words_out_q, words_out_d;
  logic [CRD_W-1:0]  pending_q, pending_d;
  logic              read_q, read_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CRD_W-1:0]  fifo_count, fcnt_nxt;
  logic [CRD_W+1:0]  credit_sum;
  logic              fifo_full, fifo_empty;
  logic              accept, push, pop, credit_ok;

  assign avm_address    = addr_q;
  assign avm_read       = read_q;
  assign avm_byteenable = '1;
  assign busy           = busy_q;
  assign done           = done_q;

  assign st_valid = ~fifo_empty;
  // framing comes from words_out_q, which only moves on a pop, so it is
  // stable while the sink stalls
  assign st_sop   = st_valid & (words_out_q == '0);
  assign st_eop   = st_valid & (words_out_q == cnt_q - CNT_W'(1));

  assign accept = read_q & ~avm_waitrequest;
  // late read data after an abort lands while IDLE and is dropped
  assign push   = avm_readdatavalid & (state_q != ST_IDLE);
  assign pop    = st_valid & st_ready;

  voxel_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (avm_readdata),
    .pop       (pop),
    .pop_data  (st_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    issued_d    = issued_q;
    words_out_d = words_out_q + CNT_W'(pop);
    pending_d   = pending_q + CRD_W'(accept) - CRD_W'(push);
    read_d      = read_q;

    if (accept) begin
      addr_d   = addr_q + ADDR_W'(1);
      issued_d = issued_q + CNT_W'(1);
    end

    // Credit is judged on next-cycle occupancy: words in flight plus words
    // buffered plus the request about to be raised must fit the FIFO, so
    // every returned word is guaranteed a slot.
    fcnt_nxt   = fifo_count + CRD_W'(push) - CRD_W'(pop);
    credit_sum = {2'b00, pending_d} + {2'b00, fcnt_nxt} + (CRD_W+2)'(1);
    credit_ok  = (credit_sum <= (CRD_W+2)'(FIFO_DEPTH)) & ~(fifo_full & ~pop);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          cnt_d       = word_count;
          issued_d    = '0;
          words_out_d = '0;
          if (word_count == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            read_d  = 1'b1;  // FIFO empty and nothing pending: credit is free
          end
        end
      end
      ST_ISSUE: begin
        if (accept && issued_q == cnt_q - CNT_W'(1)) begin
          state_d = ST_DRAIN;
          read_d  = 1'b0;
        end else if (!(read_q && !accept)) begin
          // a stalled request stays up untouched; otherwise re-arm on credit
          read_d = credit_ok;
        end
      end
      ST_DRAIN: begin
        if (pop && st_eop) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      issued_q    <= '0;
      words_out_q <= '0;
      pending_q   <= '0;
      read_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      issued_q    <= issued_d;
      words_out_q <= words_out_d;
      pending_q   <= pending_d;
      read_q      <= read_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_voxel_mm_burst_reader.sv
// Directed bench for voxel_mm_burst_reader: RAM slave model with variable
// latency/waitrequest, stream sink recorder, hand-derived expectations.
module tb_voxel_mm_burst_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] word_count = '0;
  logic        busy, done, avm_read;
  logic [9:0]  avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic [31:0] st_data;
  logic        st_valid, st_sop, st_eop;
  logic        st_ready = 1'b0;

  voxel_mm_burst_reader dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .base_addr         (base_addr),
    .word_count        (word_count),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .st_data           (st_data),
    .st_valid          (st_valid),
    .st_ready          (st_ready),
    .st_sop            (st_sop),
    .st_eop            (st_eop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [9:0] addr;
  } rsp_t;

  rsp_t        rq[$];
  logic [31:0] got_data[$];
  logic [1:0]  got_fl[$];
  logic [9:0]  req_addr[$];
  int cyc = 0, last_due = 0, n_acc = 0, n_pop = 0, max_occ = 0;
  int done_cnt = 0, done_cyc = 0, eop_cyc = 0, busy_cyc = 0;
  int lat_max = 1;
  logic wr_rand = 1'b0, rdy_rand = 1'b0, rdy_en = 1'b0;
  logic stall_q = 1'b0;
  logic [9:0] stall_addr = '0;
  int n_chk = 0, n_pass = 0;

  // RAM contents
  function automatic logic [31:0] memf(input logic [9:0] a);
    return {12'hBEE, a, ~a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // slave + sink, all driven mid-cycle
  always @(negedge clk) begin
    rsp_t r;
    int   due;
    cyc++;
    if (reset_n && stall_q)
      chk("hold", 64'({avm_read, avm_address}), 64'({1'b1, stall_addr}));
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      r = rq.pop_front();
      avm_readdatavalid = 1'b1;
      avm_readdata      = memf(r.addr);
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'h0;
    end
    avm_waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    st_ready        = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_en;
    stall_q    = avm_read & avm_waitrequest & reset_n;
    stall_addr = avm_address;
    if (avm_read && !avm_waitrequest) begin
      due = cyc + int'($urandom_range(1, lat_max));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      r.due  = due;
      r.addr = avm_address;
      rq.push_back(r);
      req_addr.push_back(avm_address);
      n_acc++;
    end
    if (st_valid && st_ready) begin
      got_data.push_back(st_data);
      got_fl.push_back({st_sop, st_eop});
      n_pop++;
      if (st_eop) eop_cyc = cyc;
    end
    if (n_acc - n_pop > max_occ) max_occ = n_acc - n_pop;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cyc++;
  end

  task automatic run_start(input logic [9:0] b, input logic [10:0] n);
    @(negedge clk);
    got_data.delete(); got_fl.delete(); req_addr.delete();
    n_acc = 0; n_pop = 0; max_occ = 0; done_cnt = 0; busy_cyc = 0;
    done_cyc = 0; eop_cyc = 0;
    base_addr = b; word_count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int i = 0;
    while (done_cnt == 0 && i < 4000) begin
      @(negedge clk);
      i++;
    end
    chk("done_seen", 64'(done_cnt != 0), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_words(input logic [9:0] b, input int n);
    logic [9:0] a;
    chk("nwords", 64'(got_data.size()), 64'(n));
    chk("nreq", 64'(req_addr.size()), 64'(n));
    for (int k = 0; k < got_data.size() && k < n; k++) begin
      a = b + 10'(k);
      chk("data", 64'(got_data[k]), 64'(memf(a)));
      chk("frame", 64'(got_fl[k]), 64'({k == 0, k == n - 1}));
    end
    for (int k = 0; k < req_addr.size() && k < n; k++) begin
      a = b + 10'(k);
      chk("addr", 64'(req_addr[k]), 64'(a));
    end
    chk("ndone", 64'(done_cnt), 64'd1);
    if (n > 0) chk("done_lat", 64'(done_cyc - eop_cyc), 64'd1);
    chk("idle", 64'({busy, done, avm_read, st_valid}), 64'd0);
  endtask

  initial begin
    int i;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 64'({busy, done, avm_read, avm_address, st_valid, st_sop, st_eop}), 64'd0);
    chk("byteen", 64'(avm_byteenable), 64'hF);
    @(negedge clk);
    reset_n = 1'b1;
    rdy_en  = 1'b1;

    // basic burst
    run_start(10'h010, 11'd4); wait_done(); check_words(10'h010, 4);

    // address wrap at top of RAM
    run_start(10'h3FE, 11'd4); wait_done(); check_words(10'h3FE, 4);

    // sink blocked: credit caps outstanding + buffered at 8
    rdy_en = 1'b0;
    run_start(10'h080, 11'd32);
    repeat (40) @(negedge clk);
    #1;
    chk("crd_acc", 64'(n_acc), 64'd8);
    chk("crd_rd", 64'(avm_read), 64'd0);
    chk("crd_max", 64'(max_occ <= 8), 64'd1);
    rdy_en = 1'b1;
    wait_done(); check_words(10'h080, 32);
    chk("crd_max2", 64'(max_occ <= 8), 64'd1);

    // random stalls and latencies 1..3
    wr_rand = 1'b1; rdy_rand = 1'b1; lat_max = 3;
    run_start(10'h123, 11'd20); wait_done(); check_words(10'h123, 20);
    wr_rand = 1'b0; rdy_rand = 1'b0; lat_max = 1;

    // zero-length and single-word jobs
    run_start(10'h200, 11'd0); wait_done(); check_words(10'h200, 0);
    chk("busy_1cyc", 64'(busy_cyc), 64'd1);
    run_start(10'h3FF, 11'd1); wait_done(); check_words(10'h3FF, 1);

    // abort by reset around word 5 of 16
    run_start(10'h000, 11'd16);
    i = 0;
    while (got_data.size() < 5 && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("mid_reached", 64'(got_data.size() >= 5), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid", 64'({busy, done, avm_read, avm_address, st_valid, st_sop, st_eop}), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_done", 64'(done_cnt), 64'd0);
    chk("post_rst_idle", 64'({busy, st_valid}), 64'd0);

    // clean job after abort; a start while busy must be ignored
    run_start(10'h000, 11'd2);
    @(negedge clk);
    base_addr = 10'h300; word_count = 11'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(); check_words(10'h000, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
